rtc_time_writer: RTL and testbench

// Commits an edited BCD time (hour/min/sec + AM/PM + 12/24h format) to the

---
 rtl/rtc_time_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rtc_time_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_writer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_time_writer
// Description : Writes a validated BCD time to the RTC as three bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_writer #(
    parameter int         T_PH      = 8,
    parameter logic [7:0] ADDR_SEC  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HOUR = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       pm,
    input  logic       fmt12,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic       ad_oe,
    output logic [7:0] ad_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              c_cnt_w = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(T_PH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_AGAP = 3'd2,
        S_DATA = 3'd3,
        S_DGAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_nxt;

    logic [5:0]           r_hour;
    logic [7:0]           r_min;
    logic [7:0]           r_sec;
    logic                 r_pm;
    logic                 r_fmt12;

    logic                 w_valid;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_last;
    logic [7:0]           w_addr;
    logic [7:0]           w_data;

    logic                 w_cs_n;
    logic                 w_wr_n;
    logic                 w_a_d;
    logic                 w_ad_oe;
    logic [7:0]           w_ad_out;

    logic                 r_cs_n;
    logic                 r_wr_n;
    logic                 r_a_d;
    logic                 r_ad_oe;
    logic [7:0]           r_ad_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    function automatic logic bcd_0_59(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_ok(input logic [7:0] h, input logic f12);
        logic ok;
        if (f12)
            ok = ((h[7:4] == 4'd0) && (h[3:0] >= 4'd1) && (h[3:0] <= 4'd9)) ||
                 ((h[7:4] == 4'd1) && (h[3:0] <= 4'd2));
        else
            ok = (h <= 8'h23) && (h[3:0] <= 4'd9);
        return ok;
    endfunction

    assign w_valid  = bcd_0_59(sec_bcd) && bcd_0_59(min_bcd) && hour_ok(hour_bcd, fmt12);
    assign w_accept = (r_state == S_IDLE) && start && w_valid;
    assign w_reject = (r_state == S_IDLE) && start && !w_valid;
    assign w_last   = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_ADDR, S_AGAP, S_DATA: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == S_ADDR) ? S_AGAP :
                                  (r_state == S_AGAP) ? S_DATA : S_DGAP;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            S_DGAP: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 2'd2) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = 2'd0;
                    end else begin
                        w_state_nxt = S_ADDR;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Held copy of the time; only a start seen in IDLE may update it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_pm    <= 1'b0;
            r_fmt12 <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_hour  <= hour_bcd[5:0];
            r_min   <= min_bcd;
            r_sec   <= sec_bcd;
            r_pm    <= pm;
            r_fmt12 <= fmt12;
        end
    end

    always_comb begin
        w_addr = ADDR_SEC;
        w_data = r_sec;
        case (w_idx_nxt)
            2'd1: begin
                w_addr = ADDR_MIN;
                w_data = r_min;
            end
            2'd2: begin
                w_addr = ADDR_HOUR;
                w_data = r_fmt12 ? {1'b1, 1'b0, r_pm, r_hour[4:0]} : {2'b00, r_hour};
            end
            default: begin
                w_addr = ADDR_SEC;
                w_data = r_sec;
            end
        endcase
    end

    // Bus pins are decoded from the next state so the registered pins line up
    // with the state they belong to.
    always_comb begin
        w_cs_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_a_d    = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_out = r_ad_out;
        case (w_state_nxt)
            S_ADDR: begin
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
            end
            S_AGAP: begin
                w_cs_n  = 1'b0;
                w_ad_oe = 1'b1;
            end
            S_DATA: begin
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_data;
            end
            default: begin
                w_cs_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cs_n   <= w_cs_n;
            r_wr_n   <= w_wr_n;
            r_a_d    <= w_a_d;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            r_err    <= w_reject;
        end
    end

    assign cs_n   = r_cs_n;
    assign wr_n   = r_wr_n;
    assign rd_n   = 1'b1;
    assign a_d    = r_a_d;
    assign ad_oe  = r_ad_oe;
    assign ad_out = r_ad_out;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_time_writer
// Description : Directed bench for rtc_time_writer at T_PH=8 and T_PH=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [2];
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       pm, fmt12;
    logic       cs_n [2];
    logic       wr_n [2];
    logic       rd_n [2];
    logic       a_d [2];
    logic       ad_oe [2];
    logic [7:0] ad_out [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ka, base, dc;

    int         ncap [2]     = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         done_cyc [2] = '{0, 0};
    logic       prev_wr [2]  = '{1'b1, 1'b1};
    logic [7:0] cap_addr [2][64];
    logic [7:0] cap_data [2][64];
    int         cap_dcyc [2][64];

    always #5 clk = ~clk;

    rtc_time_writer #(.T_PH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start[0]),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .pm(pm), .fmt12(fmt12),
        .cs_n(cs_n[0]), .wr_n(wr_n[0]), .rd_n(rd_n[0]), .a_d(a_d[0]),
        .ad_oe(ad_oe[0]), .ad_out(ad_out[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0])
    );

    rtc_time_writer #(.T_PH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .pm(pm), .fmt12(fmt12),
        .cs_n(cs_n[1]), .wr_n(wr_n[1]), .rd_n(rd_n[1]), .a_d(a_d[1]),
        .ad_oe(ad_oe[1]), .ad_out(ad_out[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: records address/data at each falling write strobe.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            prev_wr[d] <= wr_n[d];
            if (done[d]) begin
                done_cnt[d] <= done_cnt[d] + 1;
                done_cyc[d] <= cyc;
            end
            if (!cs_n[d] && !wr_n[d] && prev_wr[d] && ad_oe[d] && ncap[d] < 64) begin
                if (a_d[d]) begin
                    cap_addr[d][ncap[d]] <= ad_out[d];
                end else begin
                    cap_data[d][ncap[d]] <= ad_out[d];
                    cap_dcyc[d][ncap[d]] <= cyc;
                    ncap[d]              <= ncap[d] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_xfer(input int d, input int b, input logic [7:0] s,
                            input logic [7:0] m, input logic [7:0] h);
        chk("addr_sec", 32'(cap_addr[d][b]),     32'h21);
        chk("data_sec", 32'(cap_data[d][b]),     32'(s));
        chk("addr_min", 32'(cap_addr[d][b + 1]), 32'h22);
        chk("data_min", 32'(cap_data[d][b + 1]), 32'(m));
        chk("addr_hr",  32'(cap_addr[d][b + 2]), 32'h23);
        chk("data_hr",  32'(cap_data[d][b + 2]), 32'(h));
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic p, input logic f);
        hour_bcd = h;
        min_bcd  = m;
        sec_bcd  = s;
        pm       = p;
        fmt12    = f;
    endtask

    task automatic pulse(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        set_time(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        chk("rst_cs_n",   32'(cs_n[0]),   32'd1);
        chk("rst_wr_n",   32'(wr_n[0]),   32'd1);
        chk("rst_rd_n",   32'(rd_n[0]),   32'd1);
        chk("rst_a_d",    32'(a_d[0]),    32'd1);
        chk("rst_ad_oe",  32'(ad_oe[0]),  32'd0);
        chk("rst_ad_out", 32'(ad_out[0]), 32'd0);
        chk("rst_busy",   32'(busy[0]),   32'd0);
        chk("rst_done",   32'(done[0]),   32'd0);
        chk("rst_err",    32'(err[0]),    32'd0);
        reset = 1'b0;
        tick();

        // 24h 23:59:58
        set_time(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
        base = ncap[0];
        dc   = done_cnt[0];
        pulse(0);
        ka = cyc;
        chk("t1_cs_low",   32'(cs_n[0]),   32'd0);
        chk("t1_busy",     32'(busy[0]),   32'd1);
        chk("t1_wr_low",   32'(wr_n[0]),   32'd0);
        chk("t1_addr0",    32'(ad_out[0]), 32'h21);
        repeat (96) tick();
        chk("t1_done",     32'(done[0]),   32'd1);
        tick();
        chk("t1_busy_end", 32'(busy[0]),   32'd0);
        chk("t1_done_cyc", 32'(done_cyc[0]), 32'(ka + 96));
        chk("t1_done_cnt", 32'(done_cnt[0]), 32'(dc + 1));
        chk("t1_dcyc",     32'(cap_dcyc[0][base]), 32'(ka + 16));
        chk_xfer(0, base, 8'h58, 8'h59, 8'h23);

        // 12h 11:05:00 PM, with a second start mid-transaction and in DONE
        set_time(8'h11, 8'h05, 8'h00, 1'b1, 1'b1);
        base = ncap[0];
        dc   = done_cnt[0];
        pulse(0);
        ka = cyc;
        repeat (39) tick();
        set_time(8'h01, 8'h33, 8'h44, 1'b0, 1'b0);
        pulse(0);
        chk("t2_busy_mid", 32'(busy[0]), 32'd1);
        repeat (56) tick();
        chk("t2_done",     32'(done[0]), 32'd1);
        pulse(0);
        chk("t2_busy_end", 32'(busy[0]), 32'd0);
        chk("t2_cs_end",   32'(cs_n[0]), 32'd1);
        repeat (3) tick();
        chk("t2_no_restart", 32'(busy[0]), 32'd0);
        chk("t2_done_once",  32'(done_cnt[0]), 32'(dc + 1));
        chk_xfer(0, base, 8'h00, 8'h05, 8'hB1);

        // Invalid inputs
        set_time(8'h24, 8'h00, 8'h00, 1'b0, 1'b0);
        pulse(0);
        chk("t3a_err",  32'(err[0]),  32'd1);
        chk("t3a_cs",   32'(cs_n[0]), 32'd1);
        chk("t3a_busy", 32'(busy[0]), 32'd0);
        tick();
        chk("t3a_err_pulse", 32'(err[0]), 32'd0);
        set_time(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        pulse(0);
        chk("t3b_err",  32'(err[0]),  32'd1);
        chk("t3b_busy", 32'(busy[0]), 32'd0);
        tick();
        set_time(8'h12, 8'h60, 8'h00, 1'b0, 1'b0);
        pulse(0);
        chk("t3c_err",  32'(err[0]),  32'd1);
        tick();
        chk("t3c_busy", 32'(busy[0]), 32'd0);
        chk("t3c_cs",   32'(cs_n[0]), 32'd1);

        // Reset during the minutes data phase
        set_time(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        dc = done_cnt[0];
        pulse(0);
        ka = cyc;
        repeat (50) tick();
        chk("t5_in_data", 32'(a_d[0]),    32'd0);
        chk("t5_min_byte", 32'(ad_out[0]), 32'h34);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_cs_rel",  32'(cs_n[0]),  32'd1);
        chk("t5_oe_rel",  32'(ad_oe[0]), 32'd0);
        chk("t5_busy",    32'(busy[0]),  32'd0);
        repeat (110) tick();
        chk("t5_no_done", 32'(done_cnt[0]), 32'(dc));
        set_time(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
        base = ncap[0];
        pulse(0);
        ka = cyc;
        repeat (96) tick();
        chk("t5_done",     32'(done[0]), 32'd1);
        tick();
        chk("t5_busy_end", 32'(busy[0]), 32'd0);
        chk_xfer(0, base, 8'h09, 8'h08, 8'h07);

        // Single-cycle phases
        set_time(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
        base = ncap[1];
        pulse(1);
        ka = cyc;
        chk("t6_cs_low", 32'(cs_n[1]), 32'd0);
        repeat (11) tick();
        chk("t6_not_yet", 32'(done[1]), 32'd0);
        tick();
        chk("t6_done",    32'(done[1]), 32'd1);
        tick();
        chk("t6_busy_end", 32'(busy[1]), 32'd0);
        chk("t6_done_cyc", 32'(done_cyc[1]), 32'(ka + 12));
        chk("t6_dcyc0",    32'(cap_dcyc[1][base]),     32'(ka + 2));
        chk("t6_dcyc2",    32'(cap_dcyc[1][base + 2]), 32'(ka + 10));
        chk_xfer(1, base, 8'h58, 8'h59, 8'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
